// File: rtl/pipelined_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pipelined_adder
// Purpose  : WIDTH-bit adder split into STAGES chunks of WIDTH/STAGES bits.
//            The carry ripples one chunk per clock. Upper operand chunks and
//            finished lower sum chunks travel alongside it, so every chunk of
//            a result reaches the output in the same cycle. The pipeline uses
//            valid/ready flow control and stalls as a whole.
// Options  : PIPELINED_ADDER_OVF_EN - adds output V (signed overflow flag)
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Co
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    output logic             V
`endif
);

    // Guarded against STAGES < 1 so the illegal case reaches the check below
    // rather than dividing by zero.
    localparam int c_NSTG    = (STAGES > 0) ? STAGES : 1;
    localparam int c_CHUNK_W = WIDTH / c_NSTG;
    localparam int c_LAST    = c_NSTG - 1;

    if ((STAGES < 1) || ((WIDTH % c_NSTG) != 0)) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be a multiple of STAGES, and STAGES >= 1");
    end

    // Per-stage registers. r_a/r_b hold the operands already shifted down, so
    // the chunk a stage needs always sits in the low bits. r_sum collects the
    // finished chunks from the top down. After the last stage, chunk 0 has
    // reached bit 0.
    logic [WIDTH-1:0]     r_a   [c_NSTG];
    logic [WIDTH-1:0]     r_b   [c_NSTG];
    logic [WIDTH-1:0]     r_sum [c_NSTG];
    logic [c_NSTG-1:0]    r_cy;
    logic [c_NSTG-1:0]    r_vld;

    // Inputs to each stage: the ports for stage 0, the previous stage otherwise
    logic [WIDTH-1:0]     w_src_a   [c_NSTG];
    logic [WIDTH-1:0]     w_src_b   [c_NSTG];
    logic [WIDTH-1:0]     w_src_sum [c_NSTG];
    logic [c_NSTG-1:0]    w_src_cy;
    logic [c_NSTG-1:0]    w_src_vld;
    logic [c_CHUNK_W-1:0] w_chunk   [c_NSTG];
    logic [c_NSTG-1:0]    w_cout;

    logic                 w_advance;

    // The pipeline moves only when the output slot is empty or being drained.
    // Input bubbles travel through the pipeline and are not removed.
    assign w_advance = !r_vld[c_LAST] || out_ready;
    assign in_ready  = w_advance;

    for (genvar k = 0; k < c_NSTG; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_src_a[k]   = A;
            assign w_src_b[k]   = B;
            assign w_src_sum[k] = '0;
            assign w_src_cy[k]  = Ci;
            assign w_src_vld[k] = in_valid;
        end else begin : g_body
            assign w_src_a[k]   = r_a[k-1];
            assign w_src_b[k]   = r_b[k-1];
            assign w_src_sum[k] = r_sum[k-1];
            assign w_src_cy[k]  = r_cy[k-1];
            assign w_src_vld[k] = r_vld[k-1];
        end

        // Add this stage's chunk together with the carry from the stage below
        assign {w_cout[k], w_chunk[k]} = {1'b0, w_src_a[k][c_CHUNK_W-1:0]}
                                       + {1'b0, w_src_b[k][c_CHUNK_W-1:0]}
                                       + {{c_CHUNK_W{1'b0}}, w_src_cy[k]};

        // Stage valid, carry and partial sum: cleared by reset, held on stall
        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld[k] <= 1'b0;
                r_cy[k]  <= 1'b0;
                r_sum[k] <= '0;
            end else if (w_advance) begin
                r_vld[k] <= w_src_vld[k];
                r_cy[k]  <= w_cout[k];
                r_sum[k] <= (w_src_sum[k] >> c_CHUNK_W)
                          | (WIDTH'(w_chunk[k]) << (WIDTH - c_CHUNK_W));
            end
        end

        // Operand skew: pass the chunks not yet added to the next stage
        always_ff @(posedge clk) begin
            if (w_advance) begin
                r_a[k] <= w_src_a[k] >> c_CHUNK_W;
                r_b[k] <= w_src_b[k] >> c_CHUNK_W;
            end
        end
    end

    assign out_valid = r_vld[c_LAST];
    assign S         = r_sum[c_LAST];
    assign Co        = r_cy[c_LAST];

`ifdef PIPELINED_ADDER_OVF_EN
    logic w_msb_cin;
    logic r_ovf;

    // The carry into the MSB is recovered from the top bit of the last chunk
    assign w_msb_cin = w_src_a[c_LAST][c_CHUNK_W-1]
                     ^ w_src_b[c_LAST][c_CHUNK_W-1]
                     ^ w_chunk[c_LAST][c_CHUNK_W-1];

    // Overflow flag is registered in step with S and Co
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_advance) begin
            r_ovf <= w_msb_cin ^ w_cout[c_LAST];
        end
    end

    assign V = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_adder
// Purpose  : Self-checking bench for pipelined_adder. It uses a queue-based
//            scoreboard for the main instance and a delayed-history model for
//            the STAGES = 1/2/8 instances.
// Options  : PIPELINED_ADDER_OVF_EN - also checks output V
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] a         = '0;
    logic [15:0] b         = '0;
    logic        ci        = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] s;
    logic        co;
    logic        v;
    logic [17:0] got;

    logic [2:0]  sw_valid;
    logic [2:0]  sw_co;
    logic [2:0]  sw_v;
    logic [2:0]  sw_rdy;
    logic [47:0] sw_s;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [17:0] q_exp [$];
    int          q_cyc [$];

`ifdef PIPELINED_ADDER_OVF_EN
    localparam logic [17:0] c_MASK = 18'h3FFFF;
`else
    localparam logic [17:0] c_MASK = 18'h1FFFF;
    assign v    = 1'b0;
    assign sw_v = 3'b000;
`endif

    assign got = {v, co, s};

    pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .Ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (s),
        .Co        (co)
`ifdef PIPELINED_ADDER_OVF_EN
        ,
        .V         (v)
`endif
    );

    function automatic int sw_stages(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 2 : 8);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_sw
        pipelined_adder #(.WIDTH(16), .STAGES(sw_stages(g))) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (sw_rdy[g]),
            .A         (a),
            .B         (b),
            .Ci        (ci),
            .out_valid (sw_valid[g]),
            .out_ready (1'b1),
            .S         (sw_s[g*16 +: 16]),
            .Co        (sw_co[g])
`ifdef PIPELINED_ADDER_OVF_EN
            ,
            .V         (sw_v[g])
`endif
        );
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain 17-bit add, plus overflow from the operand/result signs
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mc);
        logic [16:0] t;
        logic        ov;
        t  = {1'b0, ma} + {1'b0, mb} + {16'h0, mc};
        ov = (ma[15] == mb[15]) && (t[15] != ma[15]);
        return {ov, t};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                         input logic ic, input logic ordy);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        ci        = ic;
        out_ready = ordy;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        step();
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_cmp++;
        if ((got & c_MASK) !== 18'h0) begin
            n_err++; $display("FAIL reset_result: got %h want 0", got & c_MASK);
        end
        rst = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        step();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_idle_valid: got %b want 0", out_valid);
        end
    endtask

    task automatic test_basic();
        logic [17:0] e;
        drive(1'b1, 16'h1234, 16'h0FCD, 1'b1, 1'b1);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL basic_in_ready: got %b want 1", in_ready);
        end
        step();
        for (int k = 1; k <= 4; k++) begin
            drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
            n_cmp++;
            if (out_valid !== (k == 4)) begin
                n_err++; $display("FAIL basic_latency: cycle %0d got %b want %b", k, out_valid, (k == 4));
            end
            if (k < 4) step();
        end
        n_cmp++;
        if ((got & c_MASK) !== (18'h02202 & c_MASK)) begin
            n_err++; $display("FAIL basic_sum: got %h want %h", got & c_MASK, 18'h02202 & c_MASK);
        end
        step();
        q_exp.delete();
        drive(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1);
        q_exp.push_back(18'h10000);
        step();
        drive(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
        q_exp.push_back(18'h28000);
        step();
        for (int t = 0; t < 10 && q_exp.size() != 0; t++) begin
            drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
            if (out_valid === 1'b1) begin
                e = q_exp.pop_front();
                n_cmp++;
                if ((got & c_MASK) !== (e & c_MASK)) begin
                    n_err++; $display("FAIL carry_result: got %h want %h", got & c_MASK, e & c_MASK);
                end
            end
            step();
        end
        n_cmp++;
        if (q_exp.size() != 0) begin
            n_err++; $display("FAIL carry_drain: got %0d pending want 0", q_exp.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] e;
        int          c;
        int          outs;
        outs = 0;
        q_exp.delete();
        q_cyc.delete();
        for (int t = 0; t < 120; t++) begin
            if (t < 100) drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
            else         drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
            if (out_valid === 1'b1) begin
                outs++;
                if (q_exp.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL stream_extra: got %h want no result", got & c_MASK);
                end else begin
                    e = q_exp.pop_front();
                    c = q_cyc.pop_front();
                    n_cmp++;
                    if ((got & c_MASK) !== (e & c_MASK)) begin
                        n_err++; $display("FAIL stream_data: got %h want %h", got & c_MASK, e & c_MASK);
                    end
                    n_cmp++;
                    if (cyc - c != 4) begin
                        n_err++; $display("FAIL stream_latency: got %0d want 4", cyc - c);
                    end
                end
            end
            if (in_valid && in_ready) begin
                q_exp.push_back(model(a, b, ci));
                q_cyc.push_back(cyc);
            end
            step();
        end
        n_cmp++;
        if (outs != 100) begin
            n_err++; $display("FAIL stream_count: got %0d want 100", outs);
        end
    endtask

    task automatic test_backpressure();
        logic [18:0] snap;
        logic [17:0] e;
        q_exp.delete();
        for (int t = 0; t < 4; t++) begin
            drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
            if (in_valid && in_ready) q_exp.push_back(model(a, b, ci));
            step();
        end
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++; $display("FAIL bp_first_valid: got %b want 1", out_valid);
        end
        snap = {out_valid, got};
        for (int j = 0; j < 5; j++) begin
            drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_err++; $display("FAIL bp_in_ready: stall %0d got %b want 0", j, in_ready);
            end
            n_cmp++;
            if ({out_valid, got} !== snap) begin
                n_err++; $display("FAIL bp_hold: stall %0d got %h want %h", j, {out_valid, got}, snap);
            end
            step();
        end
        for (int t = 0; t < 230; t++) begin
            if (t < 200) drive(($urandom_range(3) != 0), 16'($urandom), 16'($urandom),
                               1'($urandom), 1'($urandom_range(1)));
            else         drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
            if (out_valid && out_ready) begin
                if (q_exp.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL bp_extra: got %h want no result", got & c_MASK);
                end else begin
                    e = q_exp.pop_front();
                    n_cmp++;
                    if ((got & c_MASK) !== (e & c_MASK)) begin
                        n_err++; $display("FAIL bp_data: got %h want %h", got & c_MASK, e & c_MASK);
                    end
                end
            end
            if (in_valid && in_ready) q_exp.push_back(model(a, b, ci));
            step();
        end
        n_cmp++;
        if (q_exp.size() != 0) begin
            n_err++; $display("FAIL bp_lost: got %0d pending want 0", q_exp.size());
        end
    endtask

    task automatic test_reset_midflight();
        for (int t = 0; t < 3; t++) begin
            drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
            step();
        end
        rst = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        step();
        rst = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL midrst_valid: got %b want 0", out_valid);
        end
        n_cmp++;
        if ((got & c_MASK) !== 18'h0) begin
            n_err++; $display("FAIL midrst_result: got %h want 0", got & c_MASK);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL midrst_in_ready: got %b want 1", in_ready);
        end
        for (int t = 0; t < 10; t++) begin
            drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++; $display("FAIL midrst_stale: cycle %0d got %b want 0", t, out_valid);
            end
            step();
        end
    endtask

    task automatic test_sweep();
        logic        hv [64];
        logic [17:0] he [64];
        logic [17:0] sg;
        logic        ev;
        int          lat;
        rst = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        step();
        rst = 1'b0;
        for (int t = 0; t < 60; t++) begin
            drive((t < 48) && ($urandom_range(3) != 0), 16'($urandom), 16'($urandom),
                  1'($urandom), 1'b1);
            hv[t] = in_valid;
            he[t] = model(a, b, ci);
            for (int g = 0; g < 3; g++) begin
                lat = sw_stages(g);
                ev  = (t >= lat) ? hv[t-lat] : 1'b0;
                sg  = {sw_v[g], sw_co[g], sw_s[g*16 +: 16]};
                n_cmp++;
                if (sw_valid[g] !== ev) begin
                    n_err++; $display("FAIL sweep_valid: stages %0d cycle %0d got %b want %b", lat, t, sw_valid[g], ev);
                end
                if (ev) begin
                    n_cmp++;
                    if ((sg & c_MASK) !== (he[t-lat] & c_MASK)) begin
                        n_err++; $display("FAIL sweep_data: stages %0d got %h want %h", lat, sg & c_MASK, he[t-lat] & c_MASK);
                    end
                end
                n_cmp++;
                if (sw_rdy[g] !== 1'b1) begin
                    n_err++; $display("FAIL sweep_ready: stages %0d got %b want 1", lat, sw_rdy[g]);
                end
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation timed out");
    end

endmodule
`default_nettype wire
